sram_port_arb: RTL and testbench



---
 rtl/sram_port_arb.sv | 135 +++++++++++++
 tb/tb_sram_port_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arb.sv
// Two-master round-robin arbiter for the banked SRAM core port, with bounded lock-hold
// ownership and a one-cycle registered read return to the owning master.
//
// state | meaning
// IDLE  | no owner; arbitrate round-robin against last
// OWN0  | m0 holds the port while it keeps requesting
// OWN1  | m1 holds the port while it keeps requesting
module sram_port_arb #(
    parameter int MAX_HOLD = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_wr,
    input  logic [13:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_wr,
    input  logic [13:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        sram_w_en,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic [3:0]  bank0_csn,
    output logic [3:0]  bank1_csn,
    input  logic [63:0] sram_q
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state, state_nx;
    logic            last, last_nx;
    logic [HW-1:0]   hold_cnt, hold_nx, hold_eff;
    logic            accept, sel1, sel_lock, sel_wr;
    logic [13:0]     sel_addr;
    logic [3:0]      sel_be, be_eff;
    logic [31:0]     sel_wdata, rd_word;
    logic            rd_pending, rd_owner, rd_bank;
    logic [12:0]     addr_q;
    logic [31:0]     wdata_q;

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        hold_eff = '0;
        if (!hreset) begin
            if (state == OWN0 && m0_req) begin
                m0_gnt   = 1'b1;
                hold_eff = hold_cnt;
            end else if (state == OWN1 && m1_req) begin
                m1_gnt   = 1'b1;
                hold_eff = hold_cnt;
            end else if (m0_req && m1_req) begin
                // last==1 means m1 was served most recently, so m0 goes next
                m0_gnt = last;
                m1_gnt = !last;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign accept    = m0_gnt | m1_gnt;
    assign sel1      = m1_gnt;
    assign sel_lock  = sel1 ? m1_lock  : m0_lock;
    assign sel_wr    = sel1 ? m1_wr    : m0_wr;
    assign sel_addr  = sel1 ? m1_addr  : m0_addr;
    assign sel_be    = sel1 ? m1_be    : m0_be;
    assign sel_wdata = sel1 ? m1_wdata : m0_wdata;

    always_comb begin
        state_nx = IDLE;
        last_nx  = last;
        hold_nx  = '0;
        if (accept) begin
            last_nx = sel1;
            if (sel_lock && hold_eff != HW'(MAX_HOLD - 1)) begin
                state_nx = sel1 ? OWN1 : OWN0;
                hold_nx  = hold_eff + HW'(1);
            end
        end
    end

    assign be_eff     = sel_wr ? sel_be : 4'hF;
    assign bank0_csn  = (accept && !sel_addr[13]) ? ~be_eff : 4'hF;
    assign bank1_csn  = (accept &&  sel_addr[13]) ? ~be_eff : 4'hF;
    assign sram_w_en  = accept & sel_wr;
    assign sram_addr  = accept ? sel_addr[12:0] : addr_q;
    assign sram_wdata = accept ? sel_wdata : wdata_q;

    // Gating with hreset drops a return whose read was accepted just before reset.
    assign m0_rvalid = rd_pending && !rd_owner && !hreset;
    assign m1_rvalid = rd_pending &&  rd_owner && !hreset;
    assign rd_word   = rd_bank ? sram_q[63:32] : sram_q[31:0];
    assign m0_rdata  = m0_rvalid ? rd_word : 32'h0;
    assign m1_rdata  = m1_rvalid ? rd_word : 32'h0;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= IDLE;
            last       <= 1'b1;
            hold_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
            rd_bank    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nx;
            last       <= last_nx;
            hold_cnt   <= hold_nx;
            rd_pending <= accept && !sel_wr;
            if (accept) begin
                rd_owner <= sel1;
                rd_bank  <= sel_addr[13];
                addr_q   <= sel_addr[12:0];
                wdata_q  <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: directed scenarios with closed-form expectations, then a
// randomized run checked against a transfer-level ownership model.
module tb_sram_port_arb;

    localparam int MAX_HOLD = 16;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        m0_req, m0_lock, m0_wr;
    logic [13:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_lock, m1_wr;
    logic [13:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        sram_w_en;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  bank0_csn, bank1_csn;
    logic [63:0] sram_q;

    int n_tests = 0;
    int n_fail  = 0;

    sram_port_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .hclk(hclk), .hreset(hreset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .sram_w_en(sram_w_en), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .bank0_csn(bank0_csn), .bank1_csn(bank1_csn), .sram_q(sram_q)
    );

    always #5 hclk = ~hclk;

    // Transfer-level model: who owns the port and how many locked transfers it has run.
    int          mdl_last, mdl_owner, mdl_run;
    int          mdl_rd_pend, mdl_rd_master, mdl_rd_bank;
    logic [12:0] mdl_held_addr;
    logic [31:0] mdl_held_wdata;
    int          e_win;
    logic        e_lock, e_wr, e_gnt0, e_gnt1, e_w_en, e_rv0, e_rv1;
    logic [13:0] e_full_addr;
    logic [3:0]  e_csn0, e_csn1;
    logic [12:0] e_addr;
    logic [31:0] e_wdata, e_rd0, e_rd1, e_sel_q;

    function automatic void model_reset_state();
        mdl_last = 1; mdl_owner = -1; mdl_run = 0; mdl_rd_pend = 0;
        mdl_rd_master = 0; mdl_rd_bank = 0;
        mdl_held_addr = '0; mdl_held_wdata = '0;
    endfunction

    function automatic void model_eval();
        logic [3:0] sel;
        e_win = -1;
        if (!hreset) begin
            if (mdl_owner == 0 && m0_req)      e_win = 0;
            else if (mdl_owner == 1 && m1_req) e_win = 1;
            else if (m0_req && m1_req)         e_win = 1 - mdl_last;
            else if (m0_req)                   e_win = 0;
            else if (m1_req)                   e_win = 1;
        end
        e_gnt0 = (e_win == 0);
        e_gnt1 = (e_win == 1);
        e_csn0 = 4'hF; e_csn1 = 4'hF; e_w_en = 1'b0;
        e_addr = mdl_held_addr; e_wdata = mdl_held_wdata;
        e_lock = 1'b0; e_wr = 1'b0; e_full_addr = '0;
        if (e_win >= 0) begin
            e_lock      = (e_win == 1) ? m1_lock : m0_lock;
            e_wr        = (e_win == 1) ? m1_wr   : m0_wr;
            e_full_addr = (e_win == 1) ? m1_addr : m0_addr;
            e_wdata     = (e_win == 1) ? m1_wdata : m0_wdata;
            e_addr      = e_full_addr[12:0];
            e_w_en      = e_wr;
            sel = e_wr ? ~((e_win == 1) ? m1_be : m0_be) : 4'h0;
            if (e_full_addr[13]) e_csn1 = sel; else e_csn0 = sel;
        end
        e_sel_q = (mdl_rd_bank == 1) ? sram_q[63:32] : sram_q[31:0];
        e_rv0 = !hreset && mdl_rd_pend == 1 && mdl_rd_master == 0;
        e_rv1 = !hreset && mdl_rd_pend == 1 && mdl_rd_master == 1;
        e_rd0 = e_rv0 ? e_sel_q : 32'h0;
        e_rd1 = e_rv1 ? e_sel_q : 32'h0;
    endfunction

    function automatic void model_commit();
        int prior;
        if (hreset) begin
            model_reset_state();
            return;
        end
        mdl_rd_pend = (e_win >= 0 && !e_wr) ? 1 : 0;
        if (e_win >= 0) begin
            mdl_rd_master  = e_win;
            mdl_rd_bank    = e_full_addr[13] ? 1 : 0;
            mdl_held_addr  = e_addr;
            mdl_held_wdata = e_wdata;
            mdl_last       = e_win;
            prior = (mdl_owner == e_win) ? mdl_run : 0;
            if (e_lock && prior + 1 < MAX_HOLD) begin
                mdl_owner = e_win; mdl_run = prior + 1;
            end else begin
                mdl_owner = -1; mdl_run = 0;
            end
        end else begin
            mdl_owner = -1; mdl_run = 0;
        end
    endfunction

    task automatic settle();
        @(negedge hclk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge hclk);
        model_commit();
        #1;
        sram_q = {$urandom(), $urandom()};
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_wr = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_wr = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        hreset = 1;
        settle();
        tick();
        hreset = 0;
    endtask

    task automatic test_reset();
        hreset = 1;
        m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 1;
        settle();
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt got %b want 00", {m0_gnt, m1_gnt});
        end
        n_tests++;
        if ({bank0_csn, bank1_csn} !== 8'hFF || sram_w_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_csn got %h/%h w_en %b want F/F 0", bank0_csn, bank1_csn, sram_w_en);
        end
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd got rv %b%b rd %h %h want 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        tick();
        idle_inputs();
        settle();
        tick();
        hreset = 0;
    endtask

    task automatic test_single_read();
        logic [63:0] q;
        do_reset();
        m0_req = 1; m0_wr = 0; m0_addr = 14'h0005;
        settle();
        n_tests++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL read_gnt got %b%b want 10", m0_gnt, m1_gnt);
        end
        n_tests++;
        if (bank0_csn !== 4'h0 || bank1_csn !== 4'hF || sram_addr !== 13'h0005 || sram_w_en !== 1'b0) begin
            n_fail++; $display("FAIL read_port got csn %h/%h addr %h w %b want 0/F 0005 0", bank0_csn, bank1_csn, sram_addr, sram_w_en);
        end
        tick();
        m0_req = 0;
        settle();
        q = sram_q;
        n_tests++;
        if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== q[31:0]) begin
            n_fail++; $display("FAIL read_return got rv %b%b rd %h want 10 %h", m0_rvalid, m1_rvalid, m0_rdata, q[31:0]);
        end
        tick();
        settle();
        n_tests++;
        if (m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL read_once got rv %b want 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_write();
        logic [31:0] wd;
        wd = $urandom();
        m1_req = 1; m1_wr = 1; m1_addr = 14'h2010; m1_be = 4'b0101; m1_wdata = wd;
        settle();
        n_tests++;
        if (m1_gnt !== 1'b1 || sram_w_en !== 1'b1 || bank1_csn !== 4'b1010 || bank0_csn !== 4'hF) begin
            n_fail++; $display("FAIL write_port got g %b w %b csn %h/%h want 1 1 F/A", m1_gnt, sram_w_en, bank0_csn, bank1_csn);
        end
        n_tests++;
        if (sram_addr !== 13'h0010 || sram_wdata !== wd) begin
            n_fail++; $display("FAIL write_data got %h %h want 0010 %h", sram_addr, sram_wdata, wd);
        end
        tick();
        idle_inputs();
        settle();
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || {bank0_csn, bank1_csn} !== 8'hFF || sram_w_en !== 1'b0) begin
            n_fail++; $display("FAIL write_after got rv %b%b csn %h%h w %b want 00 FF 0", m0_rvalid, m1_rvalid, bank0_csn, bank1_csn, sram_w_en);
        end
        n_tests++;
        if (sram_addr !== 13'h0010 || sram_wdata !== wd) begin
            n_fail++; $display("FAIL write_hold got %h %h want 0010 %h", sram_addr, sram_wdata, wd);
        end
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        m0_req = 1; m1_req = 1; m0_wr = 1; m1_wr = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            n_tests++;
            if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL alternate[%0d] got %b%b want m%0d", i, m0_gnt, m1_gnt, i % 2);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock_hold();
        do_reset();
        m0_req = 1; m0_lock = 1; m0_wr = 1; m1_req = 1; m1_lock = 0; m1_wr = 1;
        for (int i = 0; i < 40; i++) begin
            settle();
            n_tests++;
            if (m1_gnt !== (i % 17 == 16) || m0_gnt !== (i % 17 != 16)) begin
                n_fail++; $display("FAIL lock_hold[%0d] got %b%b want m1=%0d", i, m0_gnt, m1_gnt, i % 17 == 16);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_owner_drop();
        do_reset();
        m1_req = 1; m1_lock = 1; m1_wr = 1;
        settle();
        tick();
        m0_req = 1; m0_wr = 1;
        settle();
        n_tests++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL own1_keep got %b%b want 01", m0_gnt, m1_gnt);
        end
        tick();
        m1_req = 0;
        settle();
        n_tests++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL own1_drop got %b%b want 10", m0_gnt, m1_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_req = 1; m0_wr = 0; m0_addr = 14'h0123;
        settle();
        tick();
        hreset = 1; m0_req = 0;
        settle();
        n_tests++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || {m0_gnt, m1_gnt} !== 2'b00 || {bank0_csn, bank1_csn} !== 8'hFF) begin
            n_fail++; $display("FAIL reset_mid got rv %b rd %h g %b%b csn %h%h want 0", m0_rvalid, m0_rdata, m0_gnt, m1_gnt, bank0_csn, bank1_csn);
        end
        tick();
        hreset = 0;
        settle();
        n_tests++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_after got rv %b%b want 00", m0_rvalid, m1_rvalid);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            hreset   = ($urandom_range(0, 49) == 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m0_lock  = ($urandom_range(0, 3) != 0);
            m0_wr    = $urandom_range(0, 1) == 1;
            m0_addr  = 14'($urandom());
            m0_be    = 4'($urandom());
            m0_wdata = $urandom();
            m1_req   = ($urandom_range(0, 3) != 0);
            m1_lock  = ($urandom_range(0, 2) != 0);
            m1_wr    = $urandom_range(0, 1) == 1;
            m1_addr  = 14'($urandom());
            m1_be    = 4'($urandom());
            m1_wdata = $urandom();
            settle();
            n_tests++;
            if (m0_gnt !== e_gnt0 || m1_gnt !== e_gnt1) begin
                n_fail++; $display("FAIL rnd_gnt[%0d] got %b%b want %b%b", i, m0_gnt, m1_gnt, e_gnt0, e_gnt1);
            end
            n_tests++;
            if (bank0_csn !== e_csn0 || bank1_csn !== e_csn1 || sram_w_en !== e_w_en) begin
                n_fail++; $display("FAIL rnd_csn[%0d] got %h/%h w %b want %h/%h w %b", i, bank0_csn, bank1_csn, sram_w_en, e_csn0, e_csn1, e_w_en);
            end
            n_tests++;
            if (sram_addr !== e_addr || sram_wdata !== e_wdata) begin
                n_fail++; $display("FAIL rnd_port[%0d] got %h %h want %h %h", i, sram_addr, sram_wdata, e_addr, e_wdata);
            end
            n_tests++;
            if (m0_rvalid !== e_rv0 || m1_rvalid !== e_rv1 || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
                n_fail++; $display("FAIL rnd_rd[%0d] got %b%b %h %h want %b%b %h %h", i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e_rv0, e_rv1, e_rd0, e_rd1);
            end
            tick();
        end
        hreset = 0;
        idle_inputs();
    endtask

    initial begin
        hreset = 1;
        idle_inputs();
        sram_q = {$urandom(), $urandom()};
        model_reset_state();
        test_reset();
        test_single_read();
        test_write();
        test_alternate();
        test_lock_hold();
        test_owner_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
